// File: rtl/a78_cart_loader_pkg.sv
// a78_pkg: shared types and constants for the A78 cartridge loader.
//   state_e       - loader FSM states
//   OFF_*         - byte offsets of the A78 header fields
//   MAGIC         - "ATARI" signature expected at header bytes 1..5
//   DEFAULT_SIZE  - size reported for the built-in image after reset
//   sat_sub       - unsigned subtract clamped at zero
package a78_pkg;

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int unsigned OFF_MAGIC  = 1;
  localparam int unsigned OFF_SIZE   = 49;
  localparam int unsigned OFF_FLAGS  = 53;
  localparam int unsigned OFF_REGION = 57;
  localparam int unsigned OFF_SAVE   = 58;
  localparam int unsigned OFF_XM     = 63;

  localparam logic [39:0] MAGIC        = 40'h41_54_41_52_49;
  localparam logic [31:0] DEFAULT_SIZE = 32'h0000_8000;

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/a78_cart_loader_hdr_parse.sv
// a78_hdr_parse: decodes A78 header byte offsets, compares the magic and
// latches the header fields.
//   clk_i, rst_ni  - clock, async active-low reset
//   clr_i          - clear fields and match accumulator (new download)
//   wr_i           - header byte strobe
//   addr_i/data_i  - file byte offset / byte value
//   hdr_size_o     - bytes 49..52, big-endian
//   flags_o        - bytes 53..54, big-endian
//   region_o       - byte 57 bit 0
//   save_o         - byte 58
//   xm_o           - byte 63 bit 0
//   match_o        - all five magic bytes seen and equal to "ATARI"
module a78_hdr_parse
  import a78_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        wr_i,
  input  logic [24:0] addr_i,
  input  logic [7:0]  data_i,
  output logic [31:0] hdr_size_o,
  output logic [15:0] flags_o,
  output logic        region_o,
  output logic [7:0]  save_o,
  output logic        xm_o,
  output logic        match_o
);

  logic [31:0] size_q, size_d;
  logic [15:0] flags_q, flags_d;
  logic        region_q, region_d;
  logic [7:0]  save_q, save_d;
  logic        xm_q, xm_d;
  // One bit per magic byte; a byte that never arrives leaves its bit clear,
  // so a file shorter than 6 bytes can never report a match.
  logic [4:0]  mask_q, mask_d;

  always_comb begin
    size_d   = size_q;
    flags_d  = flags_q;
    region_d = region_q;
    save_d   = save_q;
    xm_d     = xm_q;
    mask_d   = mask_q;
    if (clr_i) begin
      size_d   = '0;
      flags_d  = '0;
      region_d = 1'b0;
      save_d   = '0;
      xm_d     = 1'b0;
      mask_d   = '0;
    end else if (wr_i) begin
      case (addr_i)
        25'(OFF_MAGIC + 0): mask_d[0] = (data_i == MAGIC[39:32]);
        25'(OFF_MAGIC + 1): mask_d[1] = (data_i == MAGIC[31:24]);
        25'(OFF_MAGIC + 2): mask_d[2] = (data_i == MAGIC[23:16]);
        25'(OFF_MAGIC + 3): mask_d[3] = (data_i == MAGIC[15:8]);
        25'(OFF_MAGIC + 4): mask_d[4] = (data_i == MAGIC[7:0]);
        25'(OFF_SIZE + 0):  size_d[31:24] = data_i;
        25'(OFF_SIZE + 1):  size_d[23:16] = data_i;
        25'(OFF_SIZE + 2):  size_d[15:8]  = data_i;
        25'(OFF_SIZE + 3):  size_d[7:0]   = data_i;
        25'(OFF_FLAGS + 0): flags_d[15:8] = data_i;
        25'(OFF_FLAGS + 1): flags_d[7:0]  = data_i;
        25'(OFF_REGION):    region_d      = data_i[0];
        25'(OFF_SAVE):      save_d        = data_i;
        25'(OFF_XM):        xm_d          = data_i[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      size_q   <= DEFAULT_SIZE;
      flags_q  <= '0;
      region_q <= 1'b0;
      save_q   <= '0;
      xm_q     <= 1'b0;
      mask_q   <= '0;
    end else begin
      size_q   <= size_d;
      flags_q  <= flags_d;
      region_q <= region_d;
      save_q   <= save_d;
      xm_q     <= xm_d;
      mask_q   <= mask_d;
    end
  end

  assign hdr_size_o = size_q;
  assign flags_o    = flags_q;
  assign region_o   = region_q;
  assign save_o     = save_q;
  assign xm_o       = xm_q;
  assign match_o    = &mask_q;

endmodule

// File: rtl/a78_cart_loader.sv
// a78_cart_loader: sequences a cartridge download into the single-port cart
// RAM, strips the A78 header, and shares the RAM with the console cart bus.
//   clk_sys, reset_n         - clock, async active-low reset
//   dl_active/dl_wr/dl_addr/dl_data - ioctl download stream (cart index)
//   cpu_req/cpu_addr         - console cart read request
//   cpu_data/cpu_ack         - console read data, valid while cpu_ack
//   mem_addr/mem_wdata/mem_we/mem_rdata - cart spram port
//   sys_hold                 - holds the console in reset during a load
//   is_7800, rom_size, hdr_size, cart_flags, cart_region, cart_save,
//   cart_xm, size_mismatch, overflow - load results / header fields
//   load_done                - one-cycle pulse when returning to READY
module a78_cart_loader
  import a78_pkg::*;
#(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned HDR_LEN  = 128,
  parameter int unsigned HOLD_CYC = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              sys_hold,
  output logic              is_7800,
  output logic [31:0]       rom_size,
  output logic [31:0]       hdr_size,
  output logic [15:0]       cart_flags,
  output logic              cart_region,
  output logic [7:0]        cart_save,
  output logic              cart_xm,
  output logic              size_mismatch,
  output logic              overflow,
  output logic              load_done
);

  state_e              state_q, state_d;
  logic                act_q;
  logic [15:0]         cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [31:0]         rx_end_q, rx_end_d;
  logic                is78_q, is78_d;
  logic [31:0]         rom_q, rom_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                hold_q;
  logic                ack_q;

  logic        dl_rise, dl_fall, wr;
  logic        hdr_clr, hdr_wr, hdr_match;
  logic [24:0] body_addr;
  logic        body_ovf;

  assign dl_rise = dl_active & ~act_q;
  assign dl_fall = ~dl_active & act_q;
  assign wr      = dl_wr & dl_active;
  assign hdr_wr  = wr & (state_q == ST_HEADER);

  // The match is settled after byte 5, long before the first body byte.
  assign body_addr = hdr_match ? (dl_addr - 25'(HDR_LEN)) : dl_addr;
  assign body_ovf  = (body_addr >> ADDR_W) != '0;

  a78_hdr_parse u_hdr (
    .clk_i      (clk_sys),
    .rst_ni     (reset_n),
    .clr_i      (hdr_clr),
    .wr_i       (hdr_wr),
    .addr_i     (dl_addr),
    .data_i     (dl_data),
    .hdr_size_o (hdr_size),
    .flags_o    (cart_flags),
    .region_o   (cart_region),
    .save_o     (cart_save),
    .xm_o       (cart_xm),
    .match_o    (hdr_match)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rx_end_d = rx_end_q;
    is78_d   = is78_q;
    rom_d    = rom_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    hdr_clr  = 1'b0;

    if ((state_q == ST_HEADER || state_q == ST_BODY) && dl_fall) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      is78_d  = hdr_match;
      rom_d   = sat_sub(rx_end_q, hdr_match ? 32'(HDR_LEN) : 32'd0);
    end else begin
      case (state_q)
        ST_READY, ST_HOLD: begin
          if (dl_rise) begin
            state_d  = ST_HEADER;
            hdr_clr  = 1'b1;
            ovf_d    = 1'b0;
            rx_end_d = '0;
          end else if (state_q == ST_HOLD) begin
            if (cnt_q == 16'(HOLD_CYC - 1)) begin
              state_d = ST_READY;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        ST_HEADER: begin
          if (wr) begin
            we_d     = 1'b1;
            waddr_d  = dl_addr[ADDR_W-1:0];
            wdata_d  = dl_data;
            rx_end_d = 32'(dl_addr) + 32'd1;
            if (dl_addr == 25'(HDR_LEN - 1)) state_d = ST_BODY;
          end
        end
        ST_BODY: begin
          if (wr) begin
            rx_end_d = 32'(dl_addr) + 32'd1;
            if (body_ovf) begin
              ovf_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              waddr_d = body_addr[ADDR_W-1:0];
              wdata_d = dl_data;
            end
          end
        end
        default: state_d = ST_READY;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_READY;
      act_q    <= 1'b0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rx_end_q <= '0;
      is78_q   <= 1'b1;
      rom_q    <= DEFAULT_SIZE;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      hold_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= dl_active;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rx_end_q <= rx_end_d;
      is78_q   <= is78_d;
      rom_q    <= rom_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      hold_q   <= (state_d != ST_READY);
      ack_q    <= cpu_req & (state_q == ST_READY);
    end
  end

  // Console owns the RAM port only in READY; its address is not registered
  // so the 1-cycle spram latency lines up with cpu_ack.
  assign mem_addr      = (state_q == ST_READY) ? cpu_addr : waddr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign cpu_ack       = ack_q;
  assign cpu_data      = ack_q ? mem_rdata : '0;
  assign sys_hold      = hold_q;
  assign is_7800       = is78_q;
  assign rom_size      = rom_q;
  assign size_mismatch = is78_q & (hdr_size != rom_q);
  assign overflow      = ovf_q;
  assign load_done     = done_q;

endmodule

// File: tb/tb_a78_cart_loader.sv
module tb_a78_cart_loader;

  localparam int AW = 15;
  localparam int HL = 128;
  localparam int HC = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dl_active, dl_wr;
  logic [24:0]   dl_addr;
  logic [7:0]    dl_data;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_data;
  logic          cpu_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic          sys_hold, is_7800;
  logic [31:0]   rom_size, hdr_size;
  logic [15:0]   cart_flags;
  logic          cart_region;
  logic [7:0]    cart_save;
  logic          cart_xm, size_mismatch, overflow, load_done;

  always #5 clk = ~clk;

  a78_cart_loader #(.ADDR_W(AW), .HDR_LEN(HL), .HOLD_CYC(HC)) dut (
    .clk_sys(clk), .reset_n(reset_n),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .sys_hold(sys_hold), .is_7800(is_7800), .rom_size(rom_size), .hdr_size(hdr_size),
    .cart_flags(cart_flags), .cart_region(cart_region), .cart_save(cart_save),
    .cart_xm(cart_xm), .size_mismatch(size_mismatch), .overflow(overflow),
    .load_done(load_done)
  );

  // cart spram model: registered read, 1-cycle latency
  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct { int addr; logic [7:0] data; } wexp_t;
  wexp_t      wq[$];
  logic [7:0] rq[$];
  int n_chk = 0, n_pass = 0;
  int ld_count = 0, hold_gap = 0, inj_at = -1;
  bit watch_hold = 1'b0;
  logic [7:0] hdr [128];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] pat(input int k);
    logic [31:0] u;
    u = k;
    return u[7:0] ^ u[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] fbyte(input int i, input bit is78);
    if (is78 && i < HL) return hdr[i];
    if (is78) return pat(i - HL);
    return pat(i);
  endfunction

  task automatic build_hdr(input logic [31:0] sz, input logic [15:0] fl,
                           input logic [7:0] rg, input logic [7:0] sv, input logic [7:0] xm);
    logic [39:0] m;
    m = "ATARI";
    for (int i = 0; i < HL; i++) hdr[i] = 8'h00;
    hdr[0] = 8'h01;
    hdr[1] = m[39:32]; hdr[2] = m[31:24]; hdr[3] = m[23:16];
    hdr[4] = m[15:8];  hdr[5] = m[7:0];
    hdr[49] = sz[31:24]; hdr[50] = sz[23:16]; hdr[51] = sz[15:8]; hdr[52] = sz[7:0];
    hdr[53] = fl[15:8];  hdr[54] = fl[7:0];
    hdr[57] = rg; hdr[58] = sv; hdr[63] = xm;
  endtask

  // scoreboard monitor: writes and read acks are popped and compared
  always @(negedge clk) begin
    wexp_t e;
    if (reset_n) begin
      if (mem_we) begin
        if (wq.size() == 0) chk("unexp_write", 32'(mem_we), 32'd0);
        else begin
          e = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.addr));
          chk("wr_data", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (cpu_ack) begin
        if (rq.size() == 0) chk("unexp_ack", 32'(cpu_ack), 32'd0);
        else chk("rd_data", 32'(cpu_data), 32'(rq.pop_front()));
      end
      if (load_done) ld_count++;
      if (watch_hold && !sys_hold) hold_gap++;
    end
  end

  task automatic start_dl();
    @(posedge clk); #1 dl_active = 1'b1;
  endtask

  task automatic send_bytes(input int n, input bit is78);
    int ea;
    wexp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      dl_wr = 1'b1; dl_addr = 25'(i); dl_data = fbyte(i, is78);
      cpu_req = (i == inj_at); cpu_addr = AW'(16);
      ea = (is78 && i >= HL) ? i - HL : i;
      if (ea < (1 << AW)) begin
        e.addr = ea; e.data = dl_data;
        wq.push_back(e);
      end
    end
  endtask

  task automatic stop_dl();
    @(posedge clk); #1 dl_wr = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1 dl_active = 1'b0;
  endtask

  task automatic load(input int n, input bit is78);
    start_dl(); send_bytes(n, is78); stop_dl();
  endtask

  // called right after dl_active drops; checks results and exact hold timing
  task automatic expect_end(input logic e78, input logic [31:0] erom,
                            input logic emis, input logic eovf);
    for (int j = 1; j <= HC + 1; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin
        chk("is_7800", 32'(is_7800), 32'(e78));
        chk("rom_size", rom_size, erom);
        chk("size_mismatch", 32'(size_mismatch), 32'(emis));
        chk("overflow", 32'(overflow), 32'(eovf));
        chk("hold_in_HOLD", 32'(sys_hold), 32'd1);
      end
      if (j == HC) begin
        chk("hold_before_end", 32'(sys_hold), 32'd1);
        chk("done_early", 32'(load_done), 32'd0);
      end
      if (j == HC + 1) begin
        chk("hold_released", 32'(sys_hold), 32'd0);
        chk("load_done", 32'(load_done), 32'd1);
      end
    end
    chk("writes_pending", 32'(wq.size()), 32'd0);
  endtask

  task automatic rd(input int a);
    @(posedge clk); #1 cpu_req = 1'b1; cpu_addr = AW'(a);
    rq.push_back(pat(a));
  endtask

  task automatic rd_end();
    @(posedge clk); #1 cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reads_pending", 32'(rq.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int ld0;
    reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    cpu_req = 1'b0; cpu_addr = '0;
    #23;
    chk("rst_is_7800", 32'(is_7800), 32'd1);
    chk("rst_rom_size", rom_size, 32'h8000);
    chk("rst_hdr_size", hdr_size, 32'h8000);
    chk("rst_sys_hold", 32'(sys_hold), 32'd0);
    chk("rst_flags", 32'(cart_flags), 32'd0);
    chk("rst_mismatch", 32'(size_mismatch), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    #4 reset_n = 1'b1;

    // 7800 file, 0x8000 body, plus a cpu_req during BODY (must not be acked)
    build_hdr(32'h8000, 16'h0000, 8'h00, 8'h00, 8'h00);
    ld0 = ld_count; inj_at = 200;
    start_dl();
    @(posedge clk); #1 chk("hold_rise", 32'(sys_hold), 32'd1);
    send_bytes(HL + 32'h8000, 1'b1); stop_dl();
    inj_at = -1;
    expect_end(1'b1, 32'h8000, 1'b0, 1'b0);
    @(posedge clk); #1 chk("done_one_cycle", 32'(load_done), 32'd0);
    chk("done_count_A", 32'(ld_count - ld0), 32'd1);
    chk("hdr_size_A", hdr_size, 32'h8000);
    rd(16); rd(17); rd(0); rd(32'h7FFF); rd_end();

    // raw 2600 file, 4096 bytes
    load(4096, 1'b0);
    expect_end(1'b0, 32'd4096, 1'b0, 1'b0);
    rd(32'h123); rd(4095); rd_end();

    // fields, size 0x4000, body 2^AW+3 bytes: last 3 dropped
    build_hdr(32'h4000, 16'h0102, 8'h01, 8'h01, 8'h01);
    load(HL + (1 << AW) + 3, 1'b1);
    expect_end(1'b1, 32'h8003, 1'b1, 1'b1);
    chk("hdr_size_C", hdr_size, 32'h4000);
    chk("cart_flags", 32'(cart_flags), 32'h0102);
    chk("cart_region", 32'(cart_region), 32'd1);
    chk("cart_save", 32'(cart_save), 32'd1);
    chk("cart_xm", 32'(cart_xm), 32'd1);
    rd(0); rd(32'h7FFF); rd_end();

    // 60-byte 7800 file: magic seen, rom_size saturates to 0
    build_hdr(32'h8000, 16'h0000, 8'h00, 8'h00, 8'h00);
    load(60, 1'b1);
    expect_end(1'b1, 32'd0, 1'b1, 1'b0);
    chk("flags_cleared", 32'(cart_flags), 32'd0);

    // zero-byte load
    load(0, 1'b0);
    expect_end(1'b0, 32'd0, 1'b0, 1'b0);
    chk("hdr_size_zero", hdr_size, 32'd0);

    // restart during HOLD: sys_hold stays high, one load_done
    ld0 = ld_count; hold_gap = 0;
    load(HL + 100, 1'b1);
    watch_hold = 1'b1;
    repeat (5) @(posedge clk);
    load(HL + 50, 1'b1);
    expect_end(1'b1, 32'd50, 1'b1, 1'b0);
    watch_hold = 1'b0;
    chk("hold_gap", 32'(hold_gap), 32'd0);
    chk("done_count_restart", 32'(ld_count - ld0), 32'd1);

    // reset mid-BODY aborts asynchronously
    start_dl();
    send_bytes(HL + 20, 1'b1);
    #3 reset_n = 1'b0; dl_wr = 1'b0; dl_active = 1'b0;
    #1;
    chk("abort_sys_hold", 32'(sys_hold), 32'd0);
    chk("abort_rom_size", rom_size, 32'h8000);
    chk("abort_is_7800", 32'(is_7800), 32'd1);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    wq.delete();
    #12 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
